mips_multiciclo: RTL and testbench

- Multicycle successor to the single-cycle MIPS core, sharing one ALU and one unified instruction/data memory port across FETCH/DECODE/EXEC/MEM/WB states.
- Memory sits outside the core behind a req/ready handshake, so wait-state memories are supported.
- Reset PC and memory address width are parametrised.
- Sits as the new core top-level under the SoC/testbench, replacing the separate instruction and data memories.

---
 rtl/mips_mc_pkg.sv | 66 ++++++
 rtl/mips_mc_regfile.sv | 40 ++++
 rtl/mips_multiciclo.sv | 211 +++++++++++++++++++++
 tb/tb_mips_multiciclo.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// ============================================================================
// Module   : mips_mc_pkg
// Brief    : Shared opcodes, functs, FSM encodings and ALU helper for the
//            multicycle MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mc_pkg;

    localparam int c_NUM_REGS = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
    } alu_op_t;

    // Shifts act on operand b by the shamt field; lui places b[15:0] high.
    function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_NOR: return ~(a | b);
            ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
            ALU_SLL: return b << sh;
            ALU_SRL: return b >> sh;
            ALU_LUI: return {b[15:0], 16'h0000};
            default: return a + b;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_mc_regfile.sv
// ============================================================================
// Module   : mips_mc_regfile
// Brief    : 32x32 register file, two async read ports, one sync write port,
//            $0 hardwired to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mc_regfile import mips_mc_pkg::*; #(
    parameter int NUM_REGS = c_NUM_REGS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] r_regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : r_regs[i_raddr_b];

endmodule

`default_nettype wire

// File: rtl/mips_multiciclo.sv
// ============================================================================
// Module   : mips_multiciclo
// Brief    : Multicycle MIPS core, one shared ALU and one req/ready memory port.
//            MIPS_MULTICICLO_ILLEGAL_TRAP_EN: illegal instructions halt the core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multiciclo import mips_mc_pkg::*; #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_ADDR_W = 32,
    parameter int          NUM_REGS   = c_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           pc_out,
    output logic [31:0]           instr_out,
    output logic [2:0]            state_out,
    output logic                  instr_done,
    output logic                  halted
);

    logic [2:0]  r_state, w_next;
    logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;
    logic [31:0] w_alu_a, w_alu_b, w_alu_y, w_addr32, w_rf_a, w_rf_b, w_rf_wdata;
    logic [4:0]  w_rf_waddr;
    logic        w_rf_we;
    alu_op_t     w_alu_op;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [31:0] w_sext, w_zext;
    logic        w_is_ralu, w_is_jr, w_is_ialu, w_is_mem, w_is_jump, w_taken;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_shamt  = r_ir[10:6];
    assign w_funct  = r_ir[5:0];
    assign w_sext   = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_zext   = {16'h0000, r_ir[15:0]};

    assign w_is_ralu = (w_op == OP_RTYPE) && (w_funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR,
                                                              FN_NOR, FN_SLT, FN_SLL, FN_SRL});
    assign w_is_jr   = (w_op == OP_RTYPE) && (w_funct == FN_JR);
    assign w_is_ialu = w_op inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI};
    assign w_is_mem  = w_op inside {OP_LW, OP_SW};
    assign w_is_jump = w_op inside {OP_J, OP_JAL};
    assign w_taken   = ((w_op == OP_BEQ) && (r_a == r_b)) || ((w_op == OP_BNE) && (r_a != r_b));

    mips_mc_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b),
        .i_we      (w_rf_we),
        .i_waddr   (w_rf_waddr),
        .i_wdata   (w_rf_wdata)
    );

    // Single ALU: pc+4 in FETCH, branch target in DECODE, operation in EXEC.
    always_comb begin
        w_alu_a  = r_pc;
        w_alu_b  = 32'd4;
        w_alu_op = ALU_ADD;
        case (r_state)
            ST_DECODE: w_alu_b = {w_sext[29:0], 2'b00};
            ST_EXEC: begin
                w_alu_a = r_a;
                w_alu_b = w_sext;
                if (w_is_ralu) begin
                    w_alu_b = r_b;
                    case (w_funct)
                        FN_SUB:  w_alu_op = ALU_SUB;
                        FN_AND:  w_alu_op = ALU_AND;
                        FN_OR:   w_alu_op = ALU_OR;
                        FN_NOR:  w_alu_op = ALU_NOR;
                        FN_SLT:  w_alu_op = ALU_SLT;
                        FN_SLL:  w_alu_op = ALU_SLL;
                        FN_SRL:  w_alu_op = ALU_SRL;
                        default: w_alu_op = ALU_ADD;
                    endcase
                end else begin
                    case (w_op)
                        OP_SLTI: w_alu_op = ALU_SLT;
                        OP_ANDI: begin w_alu_b = w_zext; w_alu_op = ALU_AND; end
                        OP_ORI:  begin w_alu_b = w_zext; w_alu_op = ALU_OR;  end
                        OP_LUI:  begin w_alu_b = w_zext; w_alu_op = ALU_LUI; end
                        default: w_alu_op = ALU_ADD;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign w_alu_y = alu_eval(w_alu_op, w_alu_a, w_alu_b, w_shamt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  if (mem_ready) w_next = ST_DECODE;
`ifdef MIPS_MULTICICLO_ILLEGAL_TRAP_EN
            ST_DECODE: w_next = (w_is_ralu || w_is_jr || w_is_ialu || w_is_mem || w_is_jump ||
                                 (w_op == OP_BEQ) || (w_op == OP_BNE)) ? ST_EXEC : ST_HALT;
`else
            ST_DECODE: w_next = ST_EXEC;
`endif
            ST_EXEC:   w_next = (w_is_ralu || w_is_ialu) ? ST_WB :
                                w_is_mem ? ST_MEM : ST_FETCH;
            ST_MEM:    if (mem_ready) w_next = (w_op == OP_LW) ? ST_WB : ST_FETCH;
            ST_WB:     w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_FETCH;
        endcase
    end

    // Reset gates the request so an in-flight access is abandoned uncommitted.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        w_addr32   = r_pc;
        instr_done = 1'b0;
        case (r_state)
            ST_FETCH: mem_req = !reset;
            ST_MEM: begin
                mem_req    = !reset;
                mem_we     = !reset && (w_op == OP_SW);
                w_addr32   = r_aluout;
                instr_done = !reset && (w_next == ST_FETCH);
            end
            ST_EXEC, ST_WB: instr_done = !reset && (w_next == ST_FETCH);
            default: ;
        endcase
    end

    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = w_is_ralu ? w_rd : w_rt;
        w_rf_wdata = (w_op == OP_LW) ? r_mdr : r_aluout;
        if (r_state == ST_WB) begin
            w_rf_we = 1'b1;
        end else if ((r_state == ST_EXEC) && (w_op == OP_JAL)) begin
            w_rf_we    = 1'b1;
            w_rf_waddr = 5'd31;
            w_rf_wdata = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            case (r_state)
                ST_FETCH: if (mem_ready) begin
                    r_ir <= mem_rdata;
                    r_pc <= w_alu_y;
                end
                ST_DECODE: begin
                    r_a      <= w_rf_a;
                    r_b      <= w_rf_b;
                    r_aluout <= w_alu_y;
                end
                ST_EXEC: begin
                    if (w_is_ralu || w_is_ialu || w_is_mem) r_aluout <= w_alu_y;
                    else if (w_taken)   r_pc <= r_aluout;
                    else if (w_is_jump) r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    else if (w_is_jr)   r_pc <= r_a;
                end
                ST_MEM: if (mem_ready && (w_op == OP_LW)) r_mdr <= mem_rdata;
                default: ;
            endcase
        end
    end

    assign mem_addr  = w_addr32[MEM_ADDR_W-1:0];
    assign mem_wdata = r_b;
    assign pc_out    = r_pc;
    assign instr_out = r_ir;
    assign state_out = r_state;
`ifdef MIPS_MULTICICLO_ILLEGAL_TRAP_EN
    assign halted    = (r_state == ST_HALT);
`else
    assign halted    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_multiciclo.sv
// ============================================================================
// Module   : tb_mips_multiciclo
// Brief    : Scoreboard bench: ISA-level model predicts fetches, stores and
//            per-instruction cycle counts; a monitor checks the DUT against them.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mips_multiciclo;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready, instr_done, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, instr_out;
    logic [2:0]  state_out;

    always #5 clk = ~clk;

    mips_multiciclo #(.RESET_PC(RESET_PC), .MEM_ADDR_W(32), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_out(pc_out),
        .instr_out(instr_out), .state_out(state_out), .instr_done(instr_done), .halted(halted)
    );

    // Wait-state memory: ready after wait_n cycles of an active request.
    logic [31:0] mem  [1024];
    logic [31:0] prog [1024];
    logic [31:0] img  [1024];
    int   wait_n = 0, wcnt = 0, plen = 0;
    logic load_now = 1'b0;

    assign mem_ready = mem_req && (wcnt >= wait_n);
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (load_now) begin
            for (int i = 0; i < 1024; i++) mem[i] <= prog[i];
            wcnt <= 0;
        end else begin
            wcnt <= (!mem_req || mem_ready) ? 0 : wcnt + 1;
            if (mem_req && mem_we && mem_ready) mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    logic [31:0] q_fetch [$];
    logic [63:0] q_store [$];
    int          q_len   [$];
    int          n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: samples each cycle's outputs on the falling edge.
    int          cyc = 0;
    logic        p_pend = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    always @(negedge clk) begin
        if (reset) begin
            cyc    = 0;
            p_pend = 1'b0;
        end else begin
            cyc++;
            if (p_pend) begin
                check("req_held", mem_req, 1);
                check("addr_stable", mem_addr, p_addr);
                check("we_stable", mem_we, p_we);
                if (p_we) check("wdata_stable", mem_wdata, p_wdata);
            end
            p_pend  = mem_req && !mem_ready;
            p_addr  = mem_addr;
            p_we    = mem_we;
            p_wdata = mem_wdata;
            if (mem_req && mem_ready && !mem_we && state_out == 3'd0) begin
                check("fetch_pending", q_fetch.size() > 0, 1);
                if (q_fetch.size() > 0) check("fetch_addr", mem_addr, q_fetch.pop_front());
            end
            if (mem_req && mem_ready && mem_we) begin
                check("store_pending", q_store.size() > 0, 1);
                if (q_store.size() > 0) begin
                    logic [63:0] e;
                    e = q_store.pop_front();
                    check("store_addr", mem_addr, e[63:32]);
                    check("store_data", mem_wdata, e[31:0]);
                end
            end
            if (instr_done) begin
                check("retire_pending", q_len.size() > 0, 1);
                if (q_len.size() > 0) check("instr_cycles", cyc, q_len.pop_front());
                cyc = 0;
            end
        end
    end

    function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt, input int rd, input int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(input int op, input int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) prog[i] = '0;
        plen = 0;
    endtask
    task automatic put(input logic [31:0] w);
        prog[plen] = w;
        plen++;
    endtask

    // Instruction-set interpreter: executes the image and queues what the core must show.
    task automatic run_model(input int n_max, input logic [31:0] stop_pc, input int w,
                             output bit trapped, output logic [31:0] trap_pc);
        logic [31:0] rf [32];
        logic [31:0] pc, npc, ir, a, b, se, ze, val, ea, link;
        int          len, dst;
        bit          wr, bad;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        for (int i = 0; i < 1024; i++) img[i] = prog[i];
        pc = RESET_PC; trapped = 0; trap_pc = '0;
        for (int k = 0; k < n_max && pc != stop_pc; k++) begin
            ir = img[pc[11:2]];
            q_fetch.push_back(pc);
            npc = pc + 4;
            a = rf[ir[25:21]]; b = rf[ir[20:16]];
            se = {{16{ir[15]}}, ir[15:0]}; ze = {16'h0, ir[15:0]};
            len = 4 + w; wr = 0; bad = 0; dst = ir[20:16]; val = '0;
            case (ir[31:26])
                6'h00: begin
                    wr = 1; dst = ir[15:11];
                    case (ir[5:0])
                        6'h20: val = a + b;
                        6'h22: val = a - b;
                        6'h24: val = a & b;
                        6'h25: val = a | b;
                        6'h27: val = ~(a | b);
                        6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        6'h00: val = b << ir[10:6];
                        6'h02: val = b >> ir[10:6];
                        6'h08: begin wr = 0; npc = a; len = 3 + w; end
                        default: begin wr = 0; bad = 1; end
                    endcase
                end
                6'h08: begin wr = 1; val = a + se; end
                6'h0A: begin wr = 1; val = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
                6'h0C: begin wr = 1; val = a & ze; end
                6'h0D: begin wr = 1; val = a | ze; end
                6'h0F: begin wr = 1; val = {ir[15:0], 16'h0}; end
                6'h23: begin ea = a + se; wr = 1; val = img[ea[11:2]]; len = 5 + 2 * w; end
                6'h2B: begin
                    ea = a + se; img[ea[11:2]] = b; q_store.push_back({ea, b}); len = 4 + 2 * w;
                end
                6'h04: begin if (a == b) npc = npc + (se << 2); len = 3 + w; end
                6'h05: begin if (a != b) npc = npc + (se << 2); len = 3 + w; end
                6'h02: begin npc = {npc[31:28], ir[25:0], 2'b00}; len = 3 + w; end
                6'h03: begin
                    link = pc + 4; rf[31] = link;
                    npc = {link[31:28], ir[25:0], 2'b00}; len = 3 + w;
                end
                default: bad = 1;
            endcase
            if (bad) begin
`ifdef MIPS_MULTICICLO_ILLEGAL_TRAP_EN
                trapped = 1; trap_pc = pc;
                return;
`else
                len = 3 + w;
`endif
            end
            if (wr && dst != 0) rf[dst] = val;
            q_len.push_back(len);
            pc = npc;
        end
    endtask

    task automatic start_phase(input int w, input int n_max, input logic [31:0] stop_pc,
                               output bit trapped, output logic [31:0] trap_pc);
        reset = 1'b1; wait_n = w;
        q_fetch.delete(); q_store.delete(); q_len.delete();
        load_now = 1'b1;
        @(posedge clk); #1 load_now = 1'b0;
        run_model(n_max, stop_pc, w, trapped, trap_pc);
        @(posedge clk); #1;
        check("rst_pc", pc_out, RESET_PC);
        check("rst_state", state_out, 3'd0);
        check("rst_ir", instr_out, 0);
        check("rst_req", mem_req, 0);
        check("rst_done", instr_done, 0);
        check("rst_halted", halted, 0);
        reset = 1'b0;
    endtask

    task automatic finish_phase(input bit trapped, input logic [31:0] trap_pc);
        int t = 0;
        if (trapped) begin
            while (!halted && t < 400) begin @(posedge clk); #1; t++; end
            repeat (4) @(posedge clk);
            #1;
            check("halted", halted, 1);
            check("halt_state", state_out, 3'd5);
            check("halt_pc", pc_out, trap_pc + 4);
            check("halt_ir", instr_out, 32'hFC00_0000);
        end else begin
            while (q_len.size() != 0 && t < 4000) begin @(posedge clk); t++; end
            #1;
            check("halted_low", halted, 0);
        end
        reset = 1'b1;
        check("retire_left", q_len.size(), 0);
        check("fetch_left", q_fetch.size(), 0);
        check("store_left", q_store.size(), 0);
    endtask

    task automatic gen_random(input int count);
        for (int i = 0; i < count; i++) begin
            int k, rs, rt, rd, imm, fsel;
            k = $urandom_range(0, 9); rs = $urandom_range(0, 7); rt = $urandom_range(1, 7);
            rd = $urandom_range(0, 7); imm = $urandom_range(0, 65535); fsel = $urandom_range(0, 7);
            case (k)
                0, 1, 2: case (fsel)
                    0: put(enc_r(6'h20, rs, rt, rd, 0));
                    1: put(enc_r(6'h22, rs, rt, rd, 0));
                    2: put(enc_r(6'h24, rs, rt, rd, 0));
                    3: put(enc_r(6'h25, rs, rt, rd, 0));
                    4: put(enc_r(6'h27, rs, rt, rd, 0));
                    5: put(enc_r(6'h2A, rs, rt, rd, 0));
                    6: put(enc_r(6'h00, 0, rt, rd, $urandom_range(0, 31)));
                    default: put(enc_r(6'h02, 0, rt, rd, $urandom_range(0, 31)));
                endcase
                3, 4: case (fsel % 5)
                    0: put(enc_i(6'h0A, rs, rt, imm));
                    1: put(enc_i(6'h0C, rs, rt, imm));
                    2: put(enc_i(6'h0D, rs, rt, imm));
                    3: put(enc_i(6'h0F, 0, rt, imm));
                    default: put(enc_i(6'h08, rs, rt, imm));
                endcase
                5: put(enc_i(6'h2B, 0, rt, 32'h300 + 4 * $urandom_range(0, 15)));
                6: put(enc_i(6'h23, 0, rt, 32'h300 + 4 * $urandom_range(0, 15)));
                7: put(enc_i((fsel[0] ? 6'h05 : 6'h04), rs, rt, $urandom_range(0, 1)));
                default: put(enc_i(6'h08, rs, rt, imm));
            endcase
        end
        for (int r = 1; r < 8; r++) put(enc_i(6'h2B, 0, r, 32'h380 + 4 * r));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          tr;
        logic [31:0] tpc;
        int          t;

        // Dependent ALU chain with zero-wait memory.
        clear_prog();
        put(enc_i(6'h08, 0, 1, 5)); put(enc_i(6'h08, 0, 2, 7));
        put(enc_r(6'h20, 1, 2, 3, 0)); put(enc_i(6'h2B, 0, 3, 32'h100));
        start_phase(0, 100, plen * 4, tr, tpc);
        finish_phase(tr, tpc);

        // Store then load through a 2-wait memory.
        clear_prog();
        put(enc_i(6'h08, 0, 3, 12)); put(enc_i(6'h2B, 0, 3, 16));
        put(enc_i(6'h23, 0, 4, 16)); put(enc_i(6'h2B, 0, 4, 20));
        start_phase(2, 100, plen * 4, tr, tpc);
        finish_phase(tr, tpc);

        // Control flow, $0 write discard, illegal opcode.
        clear_prog();
        prog[0]   = enc_i(6'h08, 0, 1, 3);
        prog[1]   = enc_j(6'h02, 32'h20 >> 2);
        prog[8]   = enc_i(6'h04, 1, 1, 2);
        prog[11]  = enc_i(6'h05, 1, 1, 2);
        prog[12]  = enc_j(6'h02, 32'h40 >> 2);
        prog[16]  = enc_j(6'h03, 32'h100);
        prog[17]  = enc_i(6'h2B, 0, 31, 32'h200);
        prog[18]  = enc_i(6'h08, 0, 0, 9);
        prog[19]  = enc_i(6'h2B, 0, 0, 32'h204);
        prog[20]  = 32'hFC00_0000;
        prog[21]  = enc_i(6'h2B, 0, 1, 32'h208);
        prog[256] = enc_r(6'h08, 31, 0, 0, 0);
        start_phase(0, 100, 32'h58, tr, tpc);
        finish_phase(tr, tpc);

        // Randomized programs at random wait counts.
        for (int p = 0; p < 3; p++) begin
            clear_prog();
            gen_random(24);
            start_phase($urandom_range(0, 3), 200, plen * 4, tr, tpc);
            finish_phase(tr, tpc);
        end

        // Reset during the fetch wait of a store.
        clear_prog();
        put(enc_i(6'h08, 0, 1, 5)); put(enc_i(6'h2B, 0, 1, 16));
        start_phase(4, 1, 32'hFFFF_FFFF, tr, tpc);
        t = 0;
        while (q_len.size() != 0 && t < 200) begin @(posedge clk); t++; end
        repeat (2) @(posedge clk);
        #1;
        check("fetch_wait_state", state_out, 3'd0);
        check("fetch_wait_req", mem_req, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_fetch_pc", pc_out, RESET_PC);
        check("rst_fetch_req", mem_req, 0);
        check("rst_fetch_nowrite", mem[4], 0);
        finish_phase(1'b0, tpc);

        // Reset during the memory wait of the same store.
        start_phase(4, 2, 32'hFFFF_FFFF, tr, tpc);
        t = 0;
        while (state_out != 3'd3 && t < 200) begin @(posedge clk); #1; t++; end
        check("reached_mem", state_out, 3'd3);
        @(posedge clk); #1;
        reset = 1'b1;
        q_fetch.delete(); q_store.delete(); q_len.delete();
        @(posedge clk); #1;
        check("rst_mem_pc", pc_out, RESET_PC);
        check("rst_mem_req", mem_req, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_nowrite", mem[4], 0);
        finish_phase(1'b0, tpc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
